// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Owner and FSM state encodings are used by the top and the round-robin picker.
package dmem_arb_pkg;

   localparam int AW_DEF        = 8;
   localparam int DW_DEF        = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      OWN_C = 1'b0,
      OWN_L = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_C    = 2'd1,
      S_L    = 2'd2,
      S_LOCK = 2'd3
   } state_e;

   // Grant vector position of an owner: bit 0 is the core, bit 1 the loader.
   function automatic logic [1:0] owner_gnt(input owner_e owner);
      logic [1:0] gnt;
      case (owner)
         OWN_C:   gnt = 2'b01;
         OWN_L:   gnt = 2'b10;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/dmem_arbiter_chk.sv
// Protocol properties of the arbiter, kept apart from the datapath.
// Checked only while reset is released.
module dmem_arbiter_chk (
   input logic       clk,
   input logic       rst,
   input logic [1:0] gnt,
   input logic       c_rvalid,
   input logic       l_rvalid,
   input logic       mem_we
);

   a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

   a_one_return: assert property (@(posedge clk) disable iff (rst) !(c_rvalid && l_rvalid));

   a_we_needs_grant: assert property (@(posedge clk) disable iff (rst) mem_we |-> (|gnt));

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: req[0] is the core, req[1] the loader.
// force_l hands a conflict to the loader regardless of the rotation.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_e     last_owner,
   input  logic       force_l,
   output logic [1:0] gnt
);

   // Pick at most one requester; on a conflict the one that did not go last wins.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01: gnt = owner_gnt(OWN_C);
         2'b10: gnt = owner_gnt(OWN_L);
         2'b11: begin
            if (force_l) begin
               gnt = owner_gnt(OWN_L);
            end else if (last_owner == OWN_L) begin
               gnt = owner_gnt(OWN_C);
            end else begin
               gnt = owner_gnt(OWN_L);
            end
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data memory port between the core (C) and a loader (L).
// Round-robin on conflicts; a locked loader burst is capped when the core is waiting.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   input  logic          l_lock,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   state_e        state_r;
   owner_e        last_owner_r;
   logic [CW-1:0] burst_cnt_r;
   logic          c_rvalid_r;
   logic          l_rvalid_r;
   logic [DW-1:0] c_hold_r;
   logic [DW-1:0] l_hold_r;

   logic [1:0]    gnt_s;
   logic          yield_s;
   logic          force_l_s;

   // A full locked burst with the core waiting must give the core the next slot.
   assign yield_s   = (state_r == S_LOCK) && (burst_cnt_r == BURST_MAX) && c_req;
   assign force_l_s = (state_r == S_LOCK) && l_req && l_lock && !yield_s;

   rr_arb2 u_pick (
      .req        ({l_req, c_req}),
      .last_owner (last_owner_r),
      .force_l    (force_l_s),
      .gnt        (gnt_s)
   );

   assign c_gnt = gnt_s[0];
   assign l_gnt = gnt_s[1];

   // Route the winner's command to the memory port; idle port drives zeros.
   always_comb begin
      mem_addr  = {AW{1'b0}};
      mem_we    = 1'b0;
      mem_wdata = {DW{1'b0}};
      if (gnt_s[0]) begin
         mem_addr  = c_addr;
         mem_we    = c_we;
         mem_wdata = c_wdata;
      end else if (gnt_s[1]) begin
         mem_addr  = l_addr;
         mem_we    = l_we;
         mem_wdata = l_wdata;
      end else begin
         mem_addr  = {AW{1'b0}};
         mem_we    = 1'b0;
         mem_wdata = {DW{1'b0}};
      end
   end

   // Ownership FSM: state follows this cycle's grant, plus the locked-burst counter.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_r      <= S_IDLE;
         last_owner_r <= OWN_L;
         burst_cnt_r  <= {CW{1'b0}};
      end else begin
         if (gnt_s[0]) begin
            state_r      <= S_C;
            last_owner_r <= OWN_C;
         end else if (gnt_s[1]) begin
            state_r      <= l_lock ? S_LOCK : S_L;
            last_owner_r <= OWN_L;
         end else begin
            state_r      <= S_IDLE;
            last_owner_r <= last_owner_r;
         end

         // Saturates so an uncontested loader can run past the cap without wrapping.
         if (gnt_s[0] || !l_lock) begin
            burst_cnt_r <= {CW{1'b0}};
         end else if (gnt_s[1] && (burst_cnt_r != BURST_MAX)) begin
            burst_cnt_r <= burst_cnt_r + CW'(1);
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end
      end
   end

   // Read return: flag the cycle the memory presents data and remember it afterwards.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         c_rvalid_r <= 1'b0;
         l_rvalid_r <= 1'b0;
         c_hold_r   <= {DW{1'b0}};
         l_hold_r   <= {DW{1'b0}};
      end else begin
         c_rvalid_r <= gnt_s[0] & ~c_we;
         l_rvalid_r <= gnt_s[1] & ~l_we;
         if (c_rvalid_r) begin
            c_hold_r <= mem_rdata;
         end
         if (l_rvalid_r) begin
            l_hold_r <= mem_rdata;
         end
      end
   end

   assign c_rvalid = c_rvalid_r;
   assign l_rvalid = l_rvalid_r;
   // The memory output is live only in the return cycle, so pass it straight through then.
   assign c_rdata  = c_rvalid_r ? mem_rdata : c_hold_r;
   assign l_rdata  = l_rvalid_r ? mem_rdata : l_hold_r;
   assign busy     = gnt_s[0] | gnt_s[1] | c_rvalid_r | l_rvalid_r;

   dmem_arbiter_chk u_chk (
      .clk      (CLK),
      .rst      (Reset),
      .gnt      (gnt_s),
      .c_rvalid (c_rvalid_r),
      .l_rvalid (l_rvalid_r),
      .mem_we   (mem_we)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural sync memory, directed scenarios and random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int MAX_BURST = 4;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       c_req, c_we, c_gnt, c_rvalid;
   logic [7:0] c_addr, c_wdata, c_rdata;
   logic       l_req, l_we, l_gnt, l_rvalid, l_lock;
   logic [7:0] l_addr, l_wdata, l_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we, busy;

   logic [7:0] mem [256];
   logic       mem_init;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0] ref_mem [256];
   logic       m_crv, m_lrv, m_last_l, m_locked;
   logic [7:0] m_crd, m_lrd;
   int         m_run;
   logic       ecg, elg, ocg, olg;

   always #5 CLK = ~CLK;

   dmem_arbiter dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_rvalid  (c_rvalid),
      .c_rdata   (c_rdata),
      .l_req     (l_req),
      .l_we      (l_we),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_gnt     (l_gnt),
      .l_rvalid  (l_rvalid),
      .l_rdata   (l_rdata),
      .l_lock    (l_lock),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   function automatic logic [7:0] init_val(input int i);
      case (i)
         0:       return 8'h33;
         1:       return 8'h55;
         2:       return 8'haa;
         default: return 8'(i * 7 + 1);
      endcase
   endfunction

   // Behavioural 256x8 memory with one-cycle synchronous read.
   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         mem_rdata <= 8'h00;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_crv    = 1'b0;
      m_lrv    = 1'b0;
      m_crd    = 8'h00;
      m_lrd    = 8'h00;
      m_last_l = 1'b1;
      m_locked = 1'b0;
      m_run    = 0;
   endtask

   task automatic set_c(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
      c_req = req; c_we = we; c_addr = addr; c_wdata = wd;
   endtask

   task automatic set_l(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic lock);
      l_req = req; l_we = we; l_addr = addr; l_wdata = wd; l_lock = lock;
   endtask

   // One clock: predict and compare at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      logic [7:0] ea, ew;
      logic       ewe;
      @(negedge CLK);
      ecg = 1'b0;
      elg = 1'b0;
      if (c_req && l_req) begin
         if (m_locked && l_lock && (m_run < MAX_BURST)) elg = 1'b1;
         else if (m_last_l) ecg = 1'b1;
         else elg = 1'b1;
      end else begin
         ecg = c_req;
         elg = l_req;
      end
      ea  = ecg ? c_addr  : (elg ? l_addr  : 8'h00);
      ew  = ecg ? c_wdata : (elg ? l_wdata : 8'h00);
      ewe = ecg ? c_we    : (elg ? l_we    : 1'b0);
      ocg = c_gnt;
      olg = l_gnt;
      check("gnt",       32'({c_gnt, l_gnt}),       32'({ecg, elg}));
      check("mem_we",    32'(mem_we),               32'(ewe));
      check("mem_addr",  32'(mem_addr),             32'(ea));
      check("mem_wdata", 32'(mem_wdata),            32'(ew));
      check("rvalid",    32'({c_rvalid, l_rvalid}), 32'({m_crv, m_lrv}));
      check("c_rdata",   32'(c_rdata),              32'(m_crd));
      check("l_rdata",   32'(l_rdata),              32'(m_lrd));
      check("busy",      32'(busy),                 32'(ecg | elg | m_crv | m_lrv));
      @(posedge CLK);
      if (Reset) begin
         reset_model();
      end else begin
         if (ecg && !c_we) m_crd = ref_mem[c_addr];
         if (elg && !l_we) m_lrd = ref_mem[l_addr];
         m_crv = ecg && !c_we;
         m_lrv = elg && !l_we;
         if (ecg && c_we) ref_mem[c_addr] = c_wdata;
         if (elg && l_we) ref_mem[l_addr] = l_wdata;
         if (ecg) m_last_l = 1'b0;
         else if (elg) m_last_l = 1'b1;
         m_locked = elg && l_lock;
         if (ecg || !l_lock) m_run = 0;
         else if (elg) m_run++;
      end
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      reset_model();
      set_c(1'b0, 1'b0, 8'h00, 8'h00);
      set_l(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      cycle();
      Reset = 1'b0;
   endtask

   initial begin
      int l_done, l_before;
      logic c_seen;
      Reset    = 1'b1;
      mem_init = 1'b1;
      set_c(1'b0, 1'b0, 8'h00, 8'h00);
      set_l(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      reset_model();
      cycle();
      cycle();
      Reset    = 1'b0;
      mem_init = 1'b0;

      // 1: single core read of a preloaded location
      set_c(1'b1, 1'b0, 8'h00, 8'h00);
      cycle();
      c_req = 1'b0;
      cycle();
      check("t1_rdata", 32'(c_rdata), 32'h33);

      // 2: simultaneous reads after reset, core first then strict alternation
      do_reset();
      set_c(1'b1, 1'b0, 8'h01, 8'h00);
      set_l(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) cycle();
      c_req = 1'b0;
      l_req = 1'b0;
      cycle();
      check("t2_c_rdata", 32'(c_rdata), 32'h55);
      check("t2_l_rdata", 32'(l_rdata), 32'haa);

      // 3: locked loader burst with the core waiting
      set_c(1'b1, 1'b0, 8'h10, 8'h00);
      cycle();
      c_req = 1'b0;
      set_l(1'b1, 1'b1, 8'h05, 8'hcc, 1'b1);
      set_c(1'b1, 1'b0, 8'h05, 8'h00);
      l_done   = 0;
      l_before = 0;
      c_seen   = 1'b0;
      for (int k = 0; k < 20 && l_done < 6; k++) begin
         cycle();
         if (olg) begin
            l_done++;
            if (!c_seen) l_before++;
         end
         if (ocg) begin
            c_seen = 1'b1;
            c_req  = 1'b0;
         end
         if (l_done >= 6) l_req = 1'b0;
      end
      check("t3_l_before_c", l_before, 4);
      check("t3_l_total", l_done, 6);
      l_lock = 1'b0;
      cycle();

      // 4: loader write then core read of the same address
      set_l(1'b1, 1'b1, 8'h07, 8'h5a, 1'b0);
      cycle();
      l_req = 1'b0;
      set_c(1'b1, 1'b0, 8'h07, 8'h00);
      cycle();
      c_req = 1'b0;
      cycle();
      check("t4_rdata", 32'(c_rdata), 32'h5a);

      // 5: reset between grant and return
      set_c(1'b1, 1'b0, 8'h01, 8'h00);
      cycle();
      Reset = 1'b1;
      reset_model();
      c_req = 1'b0;
      #1;
      check("t5_rvalid_drop", 32'(c_rvalid), 32'h0);
      check("t5_rdata_clear", 32'(c_rdata), 32'h0);
      cycle();
      Reset = 1'b0;
      set_c(1'b1, 1'b0, 8'h03, 8'h00);
      set_l(1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
      cycle();
      check("t5_first_c", 32'(ocg), 32'h1);
      c_req = 1'b0;
      cycle();
      l_req = 1'b0;

      // 6: idle
      for (int k = 0; k < 10; k++) cycle();
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_state", 32'(dut.state_r), 32'(dmem_arb_pkg::S_IDLE));

      // Random traffic on a small address window to provoke conflicts
      for (int k = 0; k < 400; k++) begin
         if (!c_req || ecg) begin
            if ($urandom_range(2) != 0)
               set_c(1'b1, 1'($urandom_range(1)), 8'($urandom_range(7)), 8'($urandom));
            else
               c_req = 1'b0;
         end
         if (!l_req || elg) begin
            if ($urandom_range(2) != 0)
               set_l(1'b1, 1'($urandom_range(1)), 8'($urandom_range(7)), 8'($urandom), l_lock);
            else
               l_req = 1'b0;
         end
         if ($urandom_range(7) == 0) l_lock = ~l_lock;
         cycle();
      end
      c_req = 1'b0;
      l_req = 1'b0;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
